dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-ported data memory between the CPU MEM stage and the serial debug/loader port. Each transaction uses a fixed three-cycle request/ack sequence. While the CPU's access is pending, the block asserts a stall that the pipeline uses to drive `stall_bits` for the MEM phase and all earlier phases. A saturating stall counter is exported for the debug ports.

## Interface
Parameters:
- `AW`, default 32: address width (`FULLW`).
- `DW`, default 32: data width (`FULLW`).
- `CNTW`, default 16: stall-counter width.

Ports:
- `clk` in 1: rising-edge clock.
- `nreset` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU MEM-stage access request. Already qualified by valid/LDSTR.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in AW: CPU address.
- `cpu_wdata` in DW: CPU store data.
- `cpu_ack` out 1: one-cycle completion pulse to the CPU.
- `cpu_stall` out 1: `cpu_req & ~cpu_ack`. Feeds `stall_bits`.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`: same meaning for the debug port.
- `dbg_ack` out 1: one-cycle completion pulse to the debug port.
- `rdata` out DW: load data, valid in the ack cycle, held until the next read.
- `mem_addr` out AW: address to the data RAM, for both read and write.
- `mem_we` out 1: RAM write enable.
- `mem_wdata` out DW: RAM write data.
- `mem_rdata` in DW: RAM read data, registered one cycle after the address.
- `busy` out 1: high in ACCESS and RESP.
- `stall_cnt` out CNTW: saturating count of cycles with `cpu_stall` high.

## Operation
State machine: IDLE -> ACCESS -> RESP -> IDLE.

- **IDLE**
  - If any request is high, pick a winner and latch its `we`, `addr` and `wdata` plus a grant bit `gsel`; move to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS**
  - `mem_addr` and `mem_wdata` come from the latched values.
  - `mem_we` equals the latched `we`. The write commits at the edge that ends ACCESS.
  - Move to RESP unconditionally.
- **RESP**
  - Pulse the ack of the granted port.
  - If the latched `we` = 0, load `rdata` from `mem_rdata`.
  - Move to IDLE unconditionally.

Arbitration in IDLE:
- A lone requester always wins.
- On a tie, the winner is selected by the priority bit `pri`: 0 = CPU wins, 1 = debug wins.
- After every grant, `pri` is set to favour the port that lost, i.e. `pri = ~gsel` with `gsel` 0 = CPU, 1 = debug.

Handshake rules:
- A requester holds `req`, `we`, `addr` and `wdata` stable until its ack.
- A requester deasserts `req` at the edge after its ack, unless it is issuing a new request.
- A request that is still high in IDLE is treated as a new transaction.
- The arbiter ignores requester inputs after latching them in IDLE. Changes during ACCESS or RESP have no effect on the current transaction.

Outputs outside their active states:
- `mem_we` = 0 in every state except ACCESS.
- `mem_addr` and `mem_wdata` show the latched values in all states.

Stall counter: `stall_cnt` increments on each cycle `cpu_stall` is high and saturates at all-ones; it does not wrap.

## Timing
- Reset values: state IDLE, `pri` 0, all latches 0, `rdata` 0, `stall_cnt` 0.
  - With those values the outputs are: acks 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `busy` 0.
- Latency, uncontended: request seen in IDLE in cycle T; ACCESS in T+1; ack in T+2. The CPU is stalled for 2 cycles (T and T+1).
- Contended CPU: worst-case ack at T+5, since it waits for one debug transaction first.
- Throughput: one transaction per 3 cycles. IDLE is never skipped.
- Simultaneous requests in IDLE: exactly one grant; the loser is served in the next IDLE.
- Reset mid-operation: asynchronous return to IDLE.
  - A write in ACCESS whose commit edge has not yet occurred is not performed, because `mem_we` drops asynchronously.
  - A pending ack is lost; the requester re-issues.

## Configuration
- `DMEM_ARB_DBG_PRIO_EN` defined: the debug port has fixed priority. On a tie the debug port always wins, and `pri` is unused (held at 0).
- `DMEM_ARB_DBG_PRIO_EN` undefined: round-robin arbitration via `pri`, as described under Operation.

## Test plan
- **CPU store then load.** `cpu_req`/`we`=1, `addr` 0x10, `wdata` 0xDEADBEEF; then a load from 0x10.
  - `mem_we` high only in T+1; `cpu_ack` at T+2.
  - The load returns `rdata` 0xDEADBEEF with `cpu_ack`.
  - `stall_cnt` = 4 after both transactions.
- **Tie after reset.** Both ports request loads; debug from 0x20 holding 0x5.
  - CPU acked first (T+2); debug acked at T+5 with `rdata` 0x5.
  - With `DMEM_ARB_DBG_PRIO_EN`: debug acked first instead.
- **Continuous requests from both ports (round-robin).** 12 cycles.
  - Grants alternate CPU, debug, CPU, debug; each port gets exactly 2 acks.
- **Reset during ACCESS of a store** to 0x30, which holds 0x0.
  - `mem_we` drops immediately; no ack; memory at 0x30 still reads 0x0.
- **Stall counter saturation.** `CNTW`=4; the CPU requests continuously while the debug port competes.
  - `stall_cnt` stops at 0xF and never wraps to 0.
- **Requester input change mid-transaction.** `cpu_addr` changes during ACCESS.
  - `mem_addr` stays at the latched value; the ack completes normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data RAM between the CPU MEM stage and the debug port.
// Build option DMEM_ARB_DBG_PRIO_EN: debug port wins every tie instead of round-robin via pri.
module dmem_arbiter #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  output logic            cpu_ack,
  output logic            cpu_stall,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [DW-1:0]   dbg_wdata,
  output logic            dbg_ack,
  output logic [DW-1:0]   rdata,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy,
  output logic [CNTW-1:0] stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t          r_state;
  logic            r_gsel;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata;
  logic            r_mem_we;
  logic            r_cpu_ack;
  logic            r_dbg_ack;
  logic [CNTW-1:0] r_stall_cnt;
`ifndef DMEM_ARB_DBG_PRIO_EN
  logic            r_pri;
`endif

  logic w_any_req;
  logic w_pick_dbg;
  logic w_cpu_stall;
  logic w_sel_we;

  assign w_any_req = cpu_req | dbg_req;
`ifdef DMEM_ARB_DBG_PRIO_EN
  assign w_pick_dbg = dbg_req;
`else
  assign w_pick_dbg = dbg_req & (~cpu_req | r_pri);
`endif
  assign w_sel_we    = w_pick_dbg ? dbg_we : cpu_we;
  assign w_cpu_stall = cpu_req & ~r_cpu_ack;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= S_IDLE;
      r_gsel      <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_mem_we    <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_dbg_ack   <= 1'b0;
      r_stall_cnt <= '0;
`ifndef DMEM_ARB_DBG_PRIO_EN
      r_pri       <= 1'b0;
`endif
    end else begin
      r_cpu_ack <= 1'b0;
      r_dbg_ack <= 1'b0;
      r_mem_we  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gsel   <= w_pick_dbg;
            r_we     <= w_sel_we;
            r_addr   <= w_pick_dbg ? dbg_addr  : cpu_addr;
            r_wdata  <= w_pick_dbg ? dbg_wdata : cpu_wdata;
            r_mem_we <= w_sel_we;
`ifndef DMEM_ARB_DBG_PRIO_EN
            r_pri    <= ~w_pick_dbg;
`endif
            r_state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_cpu_ack <= ~r_gsel;
          r_dbg_ack <= r_gsel;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          if (!r_we) r_rdata <= mem_rdata;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_cpu_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNTW'(1);
    end
  end

  // RAM data arrives during RESP, so the ack cycle sees it directly; the register holds it afterwards.
  assign rdata     = ((r_state == S_RESP) && !r_we) ? mem_rdata : r_rdata;
  assign cpu_ack   = r_cpu_ack;
  assign dbg_ack   = r_dbg_ack;
  assign cpu_stall = w_cpu_stall;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_mem_we;
  assign busy      = (r_state != S_IDLE);
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed and random rounds checked against a per-round timing model.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int AW = 32, DW = 32, CNTW = 4;
  localparam int SAT = (1 << CNTW) - 1;
`ifdef DMEM_ARB_DBG_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0, nreset = 1'b0;
  logic cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
  logic [AW-1:0] cpu_addr = '0, dbg_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dbg_wdata = '0;
  logic cpu_ack, cpu_stall, dbg_ack, mem_we, busy;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [CNTW-1:0] stall_cnt;

  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] ram [256];
  logic [DW-1:0] gold [256];
  logic ram_init = 1'b0;
  bit fav_dbg;
  int exp_stall;
  logic [DW-1:0] exp_rdata;

  dmem_arbiter #(.AW(AW), .DW(DW), .CNTW(CNTW)) dut (
    .clk(clk), .nreset(nreset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .rdata(rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model: data appears one cycle after the address.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
      ram[8'h20] <= 32'h5;
    end else begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fav_dbg   = 1'b0;
    exp_stall = 0;
    exp_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    cpu_req = 1'b0; dbg_req = 1'b0;
    repeat (2) @(posedge clk);
    #2 nreset = 1'b1;
    model_reset();
  endtask

  // One arbitration round from an idle arbiter; acks expected at cycle 2 (first grant) and 5 (second).
  task automatic run_round(input bit c_en, input bit c_we, input logic [AW-1:0] c_addr, input logic [DW-1:0] c_wd,
                           input bit d_en, input bit d_we, input logic [AW-1:0] d_addr, input logic [DW-1:0] d_wd);
    bit two, win_dbg;
    int e_cpu, e_dbg;
    bit f_we, s_we;
    logic [AW-1:0] f_addr, s_addr;
    two     = c_en && d_en;
    win_dbg = d_en && (!c_en || PRIO || fav_dbg);
    e_cpu   = c_en ? ((two && win_dbg) ? 5 : 2) : -1;
    e_dbg   = d_en ? ((two && !win_dbg) ? 5 : 2) : -1;
    f_we    = win_dbg ? d_we : c_we;    f_addr = win_dbg ? d_addr : c_addr;
    s_we    = win_dbg ? c_we : d_we;    s_addr = win_dbg ? c_addr : d_addr;
    @(posedge clk); #1;
    cpu_req = c_en; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    dbg_req = d_en; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wd;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check("cpu_ack", cpu_ack, c == e_cpu);
      check("dbg_ack", dbg_ack, c == e_dbg);
      check("cpu_stall", cpu_stall, c_en && (c < e_cpu));
      check("mem_we", mem_we, (c == 1 && f_we) || (c == 4 && two && s_we));
      check("busy", busy, (c == 1 || c == 2) || (two && (c == 4 || c == 5)));
      if (c == 1) check("mem_addr_first", mem_addr, f_addr);
      if (c == 4 && two) check("mem_addr_second", mem_addr, s_addr);
      if (c == e_cpu) begin
        if (c_we) gold[c_addr[7:0]] = c_wd; else exp_rdata = gold[c_addr[7:0]];
        check("cpu_rdata", rdata, exp_rdata);
      end
      if (c == e_dbg) begin
        if (d_we) gold[d_addr[7:0]] = d_wd; else exp_rdata = gold[d_addr[7:0]];
        check("dbg_rdata", rdata, exp_rdata);
      end
      @(posedge clk); #1;
      if (c == 0) begin
        // The granted requester scrambles its inputs during ACCESS; the latched values must win.
        if (win_dbg) begin dbg_addr = ~d_addr; dbg_wdata = ~d_wd; end
        else begin cpu_addr = ~c_addr; cpu_wdata = ~c_wd; end
      end
      if (c == e_cpu) cpu_req = 1'b0;
      if (c == e_dbg) dbg_req = 1'b0;
    end
    exp_stall = (exp_stall + (c_en ? e_cpu : 0) > SAT) ? SAT : exp_stall + (c_en ? e_cpu : 0);
    fav_dbg = two ? win_dbg : c_en;
    check("stall_cnt_round", stall_cnt, exp_stall);
  endtask

  initial begin
    int nc, nd;
    bit first_dbg, pdbg;
    for (int i = 0; i < 256; i++) gold[i] = '0;
    gold[8'h20] = 32'h5;
    ram_init = 1'b1;
    repeat (3) @(posedge clk);
    #1 ram_init = 1'b0;
    #1 nreset = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_cpu_ack", cpu_ack, 0);  check("rst_dbg_ack", dbg_ack, 0);
    check("rst_mem_we", mem_we, 0);    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);        check("rst_rdata", rdata, 0);
    check("rst_stall_cnt", stall_cnt, 0);

    // Tie after reset: both loads, debug reads 0x5 from 0x20
    run_round(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);

    // CPU store then load
    do_reset();
    run_round(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
    run_round(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    check("store_load_rdata", rdata, 32'hDEADBEEF);
    check("stall_after_two", stall_cnt, 4);

    // Continuous requests from both ports for 12 cycles
    do_reset();
    first_dbg = PRIO ? 1'b1 : fav_dbg;
    nc = 0; nd = 0;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      pdbg = PRIO ? 1'b1 : (first_dbg ^ ((c / 3) % 2 == 1));
      check("cont_cpu_ack", cpu_ack, (c % 3 == 2) && !pdbg);
      check("cont_dbg_ack", dbg_ack, (c % 3 == 2) && pdbg);
      if (cpu_ack) begin nc++; check("cont_cpu_rdata", rdata, gold[8'h10]); end
      if (dbg_ack) begin nd++; check("cont_dbg_rdata", rdata, gold[8'h20]); end
      @(posedge clk); #1;
    end
    cpu_req = 0; dbg_req = 0;
    check("cont_cpu_count", nc, PRIO ? 0 : 2);
    check("cont_dbg_count", nd, PRIO ? 4 : 2);
    @(negedge clk);
    exp_stall = PRIO ? 12 : 10;
    if (exp_stall > SAT) exp_stall = SAT;
    exp_rdata = gold[PRIO ? 8'h20 : (first_dbg ? 8'h10 : 8'h20)];
    fav_dbg = first_dbg;
    check("cont_stall_cnt", stall_cnt, exp_stall);

    // Reset during ACCESS of a store to 0x30
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    check("rst_pre_mem_we", mem_we, 1);
    #1 nreset = 1'b0;
    #1;
    check("rst_async_mem_we", mem_we, 0);
    check("rst_async_busy", busy, 0);
    cpu_req = 0;
    @(posedge clk);
    #2 nreset = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_no_cpu_ack", cpu_ack, 0);
    end
    run_round(0, 0, 32'h0, 32'h0, 1, 0, 32'h30, 32'h0);
    check("rst_store_dropped", rdata, 32'h0);

    // Randomized rounds; CNTW=4 drives the stall counter into saturation
    for (int r = 0; r < 40; r++) begin
      int m;
      m = $urandom_range(1, 3);
      run_round(m[0], 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                m[1], 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
    end
    check("stall_saturated", stall_cnt, SAT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
